// File: rtl/shift_register_pkg.sv
// Shared constants, state encoding and mode helper for the sequenced
// universal shift register.
package shift_register_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD  = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD  = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL   = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHR   = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROL   = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ROR   = 3'd5;
  localparam logic [MODE_W-1:0] MODE_ASR   = 3'd6;
  localparam logic [MODE_W-1:0] MODE_CLEAR = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Only the shift/rotate modes may be run for multiple steps.
  function automatic logic is_shift_mode(input logic [MODE_W-1:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_unit.sv
// Combinational next-value datapath for the universal shift register.
module shift_unit
  import shift_register_pkg::*;
#(
  parameter int unsigned WIDTH = 7
) (
  input  logic [WIDTH-1:0]  q_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [WIDTH-1:0]  d_i,
  input  logic              sin_l_i,
  input  logic              sin_r_i,
  output logic [WIDTH-1:0]  q_next_c_o
);

  always_comb begin
    q_next_c_o = q_i;
    case (mode_i)
      MODE_HOLD:  q_next_c_o = q_i;
      MODE_LOAD:  q_next_c_o = d_i;
      MODE_SHL:   q_next_c_o = {q_i[WIDTH-2:0], sin_l_i};
      MODE_SHR:   q_next_c_o = {sin_r_i, q_i[WIDTH-1:1]};
      MODE_ROL:   q_next_c_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ROR:   q_next_c_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_ASR:   q_next_c_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      MODE_CLEAR: q_next_c_o = '0;
      default:    q_next_c_o = q_i;
    endcase
  end

endmodule

// File: rtl/shift_register_seq.sv
// Universal shift register with a multi-step sequencer: one start command
// runs a shift mode for a programmable number of enabled cycles.
module shift_register_seq
  import shift_register_pkg::*;
#(
  parameter int unsigned      WIDTH       = 7,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned      CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  D,
  input  logic              sin_l,
  input  logic              sin_r,
  input  logic              start,
  input  logic [CNT_W-1:0]  amount,
  output logic [WIDTH-1:0]  Q,
  output logic              sout_l,
  output logic              sout_r,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [MODE_W-1:0] op_mode;
  logic [WIDTH-1:0]  q_next;

  // During a run the latched mode drives the datapath; live mode is ignored.
  assign op_mode = (state_q == ST_RUN) ? mode_q : mode;

  shift_unit #(
    .WIDTH (WIDTH)
  ) u_shift_unit (
    .q_i        (q_q),
    .mode_i     (op_mode),
    .d_i        (D),
    .sin_l_i    (sin_l),
    .sin_r_i    (sin_r),
    .q_next_c_o (q_next)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (enable) begin
      case (state_q)
        ST_IDLE: begin
          if (start && is_shift_mode(mode)) begin
            // Accept edge leaves Q untouched; zero-length runs finish at once.
            if (amount != '0) begin
              mode_d  = mode;
              cnt_d   = amount;
              state_d = ST_RUN;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            q_d = q_next;
          end
        end
        ST_RUN: begin
          q_d   = q_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      q_q     <= RESET_VALUE;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
